// File: rtl/aes_block_gatherer_pkg.sv
// Shared constants and types for the AES block gatherer: frame geometry,
// counter widths and the gatherer state encoding.
package aes_gather_pkg;

  localparam int LANES           = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;            // 4
  localparam int WORDS_PER_FRAME = LANES * WORDS_PER_BLOCK;     // 128
  localparam int FRAME_W         = LANES * BLOCK_W;             // 4096
  localparam int WCNT_W          = $clog2(WORDS_PER_FRAME);     // 7
  localparam int LANES_W         = $clog2(LANES) + 1;           // 6, holds 1..32
  localparam int BIT_IDX_W       = $clog2(FRAME_W);             // 12

  // FILL: collecting words.  HOLD: presenting a finished frame.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } gather_state_t;

endpackage

// File: rtl/aes_block_gatherer.sv
// Packs a 32-bit word stream into a 4096-bit frame of 32 x 128-bit lanes for
// the parallel encryptor frontend. A frame closes after 128 words or on
// in_last; short frames are zero-padded and report their populated lanes.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_valid/out_ready may change freely; in_ready and out_valid depend only on
// the state register, so no input reaches either ready or valid combinationally.
module aes_block_gatherer
  import aes_gather_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [FRAME_W-1:0]   out_bus,
  output logic                 out_valid,
  output logic [LANES_W-1:0]   out_lanes,
  output logic                 out_last,
  input  logic                 out_ready,
  output gather_state_t        dbg_state
);

  gather_state_t        r_state;
  logic [WCNT_W-1:0]    r_wcnt;
  logic [FRAME_W-1:0]   r_bus;
  logic [LANES_W-1:0]   r_lanes;
  logic                 r_last;

  logic                 w_word_hs;
  logic                 w_frame_hs;
  logic                 w_close;
  logic [BIT_IDX_W-1:0] w_bit_base;
  logic [LANES_W-1:0]   w_lanes_next;

  // Ready/valid decoded straight from the state register.
  assign in_ready   = (r_state == FILL);
  assign out_valid  = (r_state == HOLD);

  assign w_word_hs  = in_valid  && in_ready;
  assign w_frame_hs = out_valid && out_ready;

  // Frame closes on the word that fills the last slot or carries in_last.
  assign w_close    = (r_wcnt == WCNT_W'(WORDS_PER_FRAME - 1)) || in_last;

  // Word n lands at bit n*WORD_W, so word 0 of each block sits in its LSBs.
  assign w_bit_base   = BIT_IDX_W'(r_wcnt) * BIT_IDX_W'(WORD_W);

  // A partially filled block still counts as a populated lane.
  assign w_lanes_next = LANES_W'(r_wcnt / WCNT_W'(WORDS_PER_BLOCK)) + LANES_W'(1);

  // Gatherer FSM: fill the frame word by word, then hold it until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_wcnt  <= '0;
      r_bus   <= '0;
      r_lanes <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_word_hs) begin
            r_bus[w_bit_base +: WORD_W] <= in_data;
            if (w_close) begin
              r_state <= HOLD;
              r_lanes <= w_lanes_next;
              r_last  <= in_last;
              r_wcnt  <= '0;
            end else begin
              r_wcnt  <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        HOLD: begin
          // Clearing here makes unwritten slots of the next frame read as zero.
          if (w_frame_hs) begin
            r_state <= FILL;
            r_bus   <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign out_bus   = r_bus;
  assign out_lanes = r_lanes;
  assign out_last  = r_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_block_gatherer.sv
// Bench for aes_block_gatherer: directed phases plus randomized messages,
// with a frame-level reference model feeding an expected queue and a
// monitor that checks every frame the DUT hands over.
module tb_aes_block_gatherer;
  import aes_gather_pkg::*;

  localparam int EXP_W = FRAME_W + LANES_W + 1;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [FRAME_W-1:0]  out_bus;
  logic                out_valid;
  logic [LANES_W-1:0]  out_lanes;
  logic                out_last;
  logic                out_ready;
  gather_state_t       dbg_state;

  logic dir_ready;
  logic rand_ready = 1'b1;
  logic rand_mode;
  assign out_ready = rand_mode ? rand_ready : dir_ready;

  always #5 clk = ~clk;

  aes_block_gatherer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_bus   (out_bus),
    .out_valid (out_valid),
    .out_lanes (out_lanes),
    .out_last  (out_last),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int gap_max = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [WORD_W-1:0] model_words[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: a frame is just the list of accepted words laid out in
  // order, with ceil(words/4) lanes populated.
  task automatic model_close(input logic last);
    logic [FRAME_W-1:0] b;
    int n;
    b = '0;
    n = model_words.size();
    for (int i = 0; i < n; i++) b[i*WORD_W +: WORD_W] = model_words[i];
    exp_q.push_back({last, LANES_W'((n + WORDS_PER_BLOCK - 1) / WORDS_PER_BLOCK), b});
    model_words.delete();
  endtask

  // ---------------- driver ----------------
  task automatic send_word(input logic [WORD_W-1:0] d, input logic l);
    int   guard;
    int   g;
    logic hs;
    guard = 0;
    hs    = 1'b0;
    g = int'($urandom_range(0, gap_max));
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      guard++;
    end while (!hs && guard < 3000);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!hs) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_word_timeout: got in_ready 0 expected 1 within 3000 cycles");
    end else begin
      model_words.push_back(d);
      if (model_words.size() == WORDS_PER_FRAME || l) model_close(l);
    end
  endtask

  task automatic wait_drained();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) rand_ready <= 1'($urandom_range(0, 1));

  logic [EXP_W-1:0] mon_e;
  int               mon_bad;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_unexpected: got a frame expected none (lanes %0d)", out_lanes);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_lanes", 128'(out_lanes), 128'(mon_e[FRAME_W +: LANES_W]));
        chk("frame_last", 128'(out_last), 128'(mon_e[EXP_W-1]));
        n_cmp++;
        mon_bad = -1;
        for (int w = WORDS_PER_FRAME - 1; w >= 0; w--)
          if (out_bus[w*WORD_W +: WORD_W] !== mon_e[w*WORD_W +: WORD_W]) mon_bad = w;
        if (mon_bad >= 0) begin
          n_fail++;
          $display("FAIL frame_bus: word %0d got %h expected %h", mon_bad,
                   out_bus[mon_bad*WORD_W +: WORD_W], mon_e[mon_bad*WORD_W +: WORD_W]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [FRAME_W-1:0] snap;
  int len;

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    dir_ready = 1'b1;
    rand_mode = 1'b0;
    rst_n     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_lanes", 128'(out_lanes), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_bus_nonzero", 128'(|out_bus), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, word index as data, consumer always ready.
    for (int i = 0; i < WORDS_PER_FRAME; i++) send_word(WORD_W'(i), 1'b0);
    chk("full_valid_latency", 128'(out_valid), 128'(1));
    chk("full_in_ready_low", 128'(in_ready), 128'(0));
    chk("full_bus_lo", out_bus[127:0], {32'd3, 32'd2, 32'd1, 32'd0});
    chk("full_lanes", 128'(out_lanes), 128'(32));
    chk("full_last", 128'(out_last), 128'(0));
    @(posedge clk);
    #1;
    chk("full_in_ready_return", 128'(in_ready), 128'(1));
    chk("full_valid_drop", 128'(out_valid), 128'(0));

    // Partial frame closed mid-block.
    for (int i = 0; i < 6; i++) send_word(WORD_W'(32'hA0 + i), (i == 5));
    chk("part_lanes", 128'(out_lanes), 128'(2));
    chk("part_last", 128'(out_last), 128'(1));
    chk("part_word5", 128'(out_bus[191:160]), 128'(32'hA5));
    chk("part_pad_block", 128'(out_bus[255:192]), 128'(0));
    chk("part_upper_nonzero", 128'(|out_bus[FRAME_W-1:256]), 128'(0));
    @(posedge clk);
    #1;

    // Backpressure: frame held while a stray word is offered.
    dir_ready = 1'b0;
    for (int i = 0; i < WORDS_PER_FRAME; i++) send_word($urandom, 1'b0);
    snap     = out_bus;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_last  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_bus_stable", 128'(out_bus == snap), 128'(1));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    dir_ready = 1'b1;
    @(posedge clk);
    #1;

    // Padding after a full all-ones frame.
    for (int i = 0; i < WORDS_PER_FRAME; i++) send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'h12345678, 1'b1);
    chk("pad_lanes", 128'(out_lanes), 128'(1));
    chk("pad_last", 128'(out_last), 128'(1));
    chk("pad_word0", 128'(out_bus[31:0]), 128'(32'h12345678));
    chk("pad_rest_nonzero", 128'(|out_bus[FRAME_W-1:32]), 128'(0));
    @(posedge clk);
    #1;

    // Randomized messages with input gaps and random consumer stalls.
    gap_max   = 3;
    rand_mode = 1'b1;
    for (int m = 0; m < 6; m++) begin
      len = int'($urandom_range(1, 200));
      for (int k = 0; k < len; k++) send_word($urandom, (k == len - 1));
    end
    wait_drained();
    rand_mode = 1'b0;
    gap_max   = 0;
    @(posedge clk);
    #1;

    // Reset mid-frame after word 50.
    for (int i = 0; i <= 50; i++) send_word(WORD_W'(32'h100 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 128'(in_ready), 128'(1));
    chk("mrst_out_valid", 128'(out_valid), 128'(0));
    chk("mrst_out_lanes", 128'(out_lanes), 128'(0));
    chk("mrst_out_last", 128'(out_last), 128'(0));
    chk("mrst_bus_nonzero", 128'(|out_bus), 128'(0));
    model_words.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < WORDS_PER_FRAME; i++) send_word(WORD_W'(32'h5000 + i), 1'b0);
    chk("mrst_first_word", 128'(out_bus[31:0]), 128'(32'h5000));
    chk("mrst_lanes", 128'(out_lanes), 128'(32));

    wait_drained();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
